// File: rtl/boid_pkg.sv
// Shared constants and FSM encoding for the boid display path.
// Used by both the frame writer and the VGA read side.
package boid_pkg;
  localparam int VIDEO_WIDTH         = 640;
  localparam int VIDEO_HEIGHT        = 480;
  localparam int PIXEL_ADDRESS_WIDTH = 19;
  localparam int MAX_BOIDS           = 128;
  localparam int BITS_FOR_BOIDS      = $clog2(MAX_BOIDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/boid_pixel_addr.sv
// Maps a pixel coordinate to a linear display RAM address and flags on-screen pixels.
// The multiply by 640 is done as (py<<9)+(py<<7), so the line pitch is fixed at 640.
module boid_pixel_addr
  import boid_pkg::*;
(
  input  logic [10:0]                    px,
  input  logic [9:0]                     py,
  output logic                           in_bounds,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] addr
);
  logic [PIXEL_ADDRESS_WIDTH-1:0] py_w;
  logic [PIXEL_ADDRESS_WIDTH-1:0] px_w;

  assign py_w      = PIXEL_ADDRESS_WIDTH'(py);
  assign px_w      = PIXEL_ADDRESS_WIDTH'(px);
  assign in_bounds = (px < 11'(VIDEO_WIDTH)) && (py < 10'(VIDEO_HEIGHT));
  assign addr      = (py_w << 9) + (py_w << 7) + px_w;
endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame write sequencer: clears the display RAM, then walks every boid and
// plots a DOT_SIZE x DOT_SIZE square at its position, clipping off-screen pixels.
module boid_frame_writer #(
  parameter int MAX_BOIDS      = boid_pkg::MAX_BOIDS,
  parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int DOT_SIZE       = 1
) (
  input  logic                                     clock,
  input  logic                                     resetn,
  input  logic                                     refresh_req,
  input  logic [9:0]                               x_loc,
  input  logic [8:0]                               y_loc,
  output logic [BITS_FOR_BOIDS-1:0]                boid_sel,
  output logic                                     clear_pulse,
  output logic                                     pix_we,
  output logic [boid_pkg::PIXEL_ADDRESS_WIDTH-1:0] pix_addr,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic                                     overrun
);
  import boid_pkg::*;

  localparam logic [1:0]                SUB_LAST = 2'(DOT_SIZE * DOT_SIZE - 1);
  localparam logic [BITS_FOR_BOIDS-1:0] IDX_LAST = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  state_t                           state;
  logic [BITS_FOR_BOIDS-1:0]        idx;
  logic [1:0]                       sub;
  logic [9:0]                       x_r;
  logic [8:0]                       y_r;
  logic                             dx;
  logic                             dy;
  logic [10:0]                      px;
  logic [9:0]                       py;
  logic                             in_bounds;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   addr;

  // Sub-pixel offsets only exist for 2x2 dots; a 1x1 dot always sits at (x_r, y_r).
  assign dx = (DOT_SIZE == 2) ? sub[0] : 1'b0;
  assign dy = (DOT_SIZE == 2) ? sub[1] : 1'b0;
  assign px = {1'b0, x_r} + {10'b0, dx};
  assign py = {1'b0, y_r} + {9'b0, dy};

  boid_pixel_addr u_pixel_addr (
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds),
    .addr      (addr)
  );

  assign boid_sel    = idx;
  assign clear_pulse = (state == CLEAR);
  assign frame_done  = (state == DONE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      idx      <= '0;
      sub      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      pix_we   <= 1'b0;
      pix_addr <= '0;
      overrun  <= 1'b0;
    end else begin
      pix_we <= 1'b0;
      // A request arriving while a frame is in flight is dropped, not queued.
      if (refresh_req && (state == CLEAR || state == FETCH || state == DRAW))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (refresh_req) state <= CLEAR;
        end
        CLEAR: begin
          idx   <= '0;
          state <= FETCH;
        end
        FETCH: begin
          x_r   <= x_loc;
          y_r   <= y_loc;
          sub   <= '0;
          state <= DRAW;
        end
        DRAW: begin
          pix_we <= in_bounds;
          if (in_bounds) pix_addr <= addr;
          if (sub == SUB_LAST) begin
            if (idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end else begin
            sub <= sub + 2'd1;
          end
        end
        DONE: begin
          state <= refresh_req ? CLEAR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_boid_frame_writer.sv
// Bench for boid_frame_writer: a 1x1-dot and a 2x2-dot instance, each fed from a
// position table and checked against a queue of expected write addresses.
module tb_boid_frame_writer;
  localparam int NB = 128;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        refresh1, refresh2;
  logic [9:0]  xl1, xl2;
  logic [8:0]  yl1, yl2;
  logic [6:0]  sel1, sel2;
  logic        clr1, clr2, we1, we2, busy1, busy2, done1, done2, ovr1, ovr2;
  logic [18:0] addr1, addr2;

  logic [9:0]  bx1 [NB];
  logic [8:0]  by1 [NB];
  logic [9:0]  bx2 [NB];
  logic [8:0]  by2 [NB];

  assign xl1 = bx1[sel1];
  assign yl1 = by1[sel1];
  assign xl2 = bx2[sel2];
  assign yl2 = by2[sel2];

  boid_frame_writer #(.MAX_BOIDS(NB), .DOT_SIZE(1)) dut1 (
    .clock(clock), .resetn(resetn), .refresh_req(refresh1), .x_loc(xl1), .y_loc(yl1),
    .boid_sel(sel1), .clear_pulse(clr1), .pix_we(we1), .pix_addr(addr1),
    .busy(busy1), .frame_done(done1), .overrun(ovr1));

  boid_frame_writer #(.MAX_BOIDS(NB), .DOT_SIZE(2)) dut2 (
    .clock(clock), .resetn(resetn), .refresh_req(refresh2), .x_loc(xl2), .y_loc(yl2),
    .boid_sel(sel2), .clear_pulse(clr2), .pix_we(we2), .pix_addr(addr2),
    .busy(busy2), .frame_done(done2), .overrun(ovr2));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q1[$];
  int exp_q2[$];
  int stamp2[$];
  int we_cnt1 = 0, we_cnt2 = 0, clr_cnt1 = 0, clr_cnt2 = 0;
  int last_clr1 = -100, last_clr2 = -100;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Output monitor: every write is matched against the head of its expectation queue.
  always @(negedge clock) begin
    if (clr1) begin clr_cnt1++; last_clr1 = cyc; end
    if (clr2) begin clr_cnt2++; last_clr2 = cyc; end
    if (we1) begin
      we_cnt1++;
      chk("clr_before_we1", 32'((cyc - last_clr1) >= 2), 32'd1);
      if (exp_q1.size() == 0) chk("we1_extra", 32'(addr1), 32'h7FFFFFFF);
      else chk("addr1", 32'(addr1), 32'(exp_q1.pop_front()));
    end
    if (we2) begin
      we_cnt2++;
      stamp2.push_back(cyc);
      chk("clr_before_we2", 32'((cyc - last_clr2) >= 2), 32'd1);
      if (exp_q2.size() == 0) chk("we2_extra", 32'(addr2), 32'h7FFFFFFF);
      else chk("addr2", 32'(addr2), 32'(exp_q2.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic all_off(input int which);
    for (int i = 0; i < NB; i++) begin
      if (which == 1) begin bx1[i] = 10'd700; by1[i] = 9'd0; end
      else begin bx2[i] = 10'd700; by2[i] = 9'd0; end
    end
  endtask

  // Reference model: y*640+x per on-screen sub-pixel, boid index order.
  task automatic push_exp(input int which);
    int dot, px, py, dx, dy;
    dot = (which == 1) ? 1 : 2;
    for (int i = 0; i < NB; i++) begin
      for (int s = 0; s < dot * dot; s++) begin
        dx = (dot == 2) ? (s % 2) : 0;
        dy = (dot == 2) ? (s / 2) : 0;
        px = ((which == 1) ? int'(bx1[i]) : int'(bx2[i])) + dx;
        py = ((which == 1) ? int'(by1[i]) : int'(by2[i])) + dy;
        if (px < 640 && py < 480) begin
          if (which == 1) exp_q1.push_back(py * 640 + px);
          else exp_q2.push_back(py * 640 + px);
        end
      end
    end
  endtask

  task automatic start(input int which);
    if (which == 1) refresh1 = 1'b1; else refresh2 = 1'b1;
    tick();
    refresh1 = 1'b0;
    refresh2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int exp_len, input string tag);
    int n;
    n = 1;
    while (!((which == 1) ? done1 : done2) && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, n, exp_len);
  endtask

  initial begin
    int w0, c0, n;
    resetn = 1'b0; refresh1 = 1'b0; refresh2 = 1'b0;
    all_off(1); all_off(2);
    tick(); tick();
    chk("rst_we", 32'(we1), 0);
    chk("rst_addr", 32'(addr1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_clr", 32'(clr1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_ovr", 32'(ovr1), 0);
    chk("rst_sel", 32'(sel1), 0);
    resetn = 1'b1;
    tick(); tick();

    // Single on-screen boid, 1x1 dot
    bx1[0] = 10'd10; by1[0] = 9'd20;
    push_exp(1);
    w0 = we_cnt1; c0 = clr_cnt1;
    start(1);
    chk("t1_clear", 32'(clr1), 1);
    wait_done(1, 258, "t1_len");
    tick();
    chk("t1_done_pulse", 32'(done1), 0);
    chk("t1_busy_after", 32'(busy1), 0);
    chk("t1_writes", we_cnt1 - w0, 1);
    chk("t1_clears", clr_cnt1 - c0, 1);
    chk("t1_q_empty", exp_q1.size(), 0);

    // 2x2 dot in the bottom-right corner: three sub-pixels clipped
    bx2[5] = 10'd639; by2[5] = 9'd479;
    push_exp(2);
    w0 = we_cnt2;
    start(2);
    wait_done(2, 642, "t2_len");
    tick();
    chk("t2_writes", we_cnt2 - w0, 1);
    chk("t2_q_empty", exp_q2.size(), 0);

    // 2x2 dot at the origin: four consecutive writes
    all_off(2);
    bx2[0] = 10'd0; by2[0] = 9'd0;
    push_exp(2);
    stamp2.delete();
    start(2);
    wait_done(2, 642, "t3_len");
    tick();
    chk("t3_writes", stamp2.size(), 4);
    for (int k = 1; k < 4; k++)
      if (k < stamp2.size()) chk("t3_consec", stamp2[k] - stamp2[0], k);
    chk("t3_q_empty", exp_q2.size(), 0);

    // Overrun: request mid-frame is dropped
    push_exp(1);
    w0 = we_cnt1; c0 = clr_cnt1;
    start(1);
    n = 1;
    while (!done1 && n < 5000) begin
      if (n == 100) refresh1 = 1'b1;
      tick();
      refresh1 = 1'b0;
      n++;
    end
    chk("t4_len", n, 258);
    for (int k = 0; k < 5; k++) tick();
    chk("t4_ovr", 32'(ovr1), 1);
    chk("t4_no_second", 32'(busy1), 0);
    chk("t4_clears", clr_cnt1 - c0, 1);
    chk("t4_writes", we_cnt1 - w0, 1);

    // Back-to-back frame requested in the DONE cycle
    push_exp(2); push_exp(2);
    c0 = clr_cnt2;
    start(2);
    wait_done(2, 642, "t4b_len1");
    refresh2 = 1'b1;
    tick();
    refresh2 = 1'b0;
    chk("t4b_clear_next", 32'(clr2), 1);
    wait_done(2, 642, "t4b_len2");
    tick();
    chk("t4b_ovr", 32'(ovr2), 0);
    chk("t4b_clears", clr_cnt2 - c0, 2);
    chk("t4b_q_empty", exp_q2.size(), 0);

    // Asynchronous reset mid-DRAW
    for (int i = 0; i < NB; i++) begin
      bx1[i] = 10'((i * 37) % 640);
      by1[i] = 9'((i * 3) % 480 + 1);
    end
    push_exp(1);
    start(1);
    for (int k = 1; k < 51; k++) tick();
    chk("t5_busy_pre", 32'(busy1), 1);
    resetn = 1'b0;
    #1;
    chk("t5_we", 32'(we1), 0);
    chk("t5_addr", 32'(addr1), 0);
    chk("t5_busy", 32'(busy1), 0);
    chk("t5_sel", 32'(sel1), 0);
    chk("t5_ovr", 32'(ovr1), 0);
    chk("t5_clr", 32'(clr1), 0);
    chk("t5_done", 32'(done1), 0);
    tick(); tick();
    resetn = 1'b1;
    exp_q1.delete();
    w0 = we_cnt1;
    for (int k = 0; k < 300; k++) tick();
    chk("t5_no_we", we_cnt1 - w0, 0);
    chk("t5_idle", 32'(busy1), 0);

    // All boids on-screen and distinct
    push_exp(1);
    w0 = we_cnt1;
    start(1);
    wait_done(1, 258, "t6_len");
    tick();
    chk("t6_writes", we_cnt1 - w0, 128);
    chk("t6_q_empty", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
